mem_rr_arbiter: RTL and testbench



---
 rtl/mem_rr_arbiter_if.sv | 14 +
 rtl/mem_rr_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_rr_arbiter.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_rr_arbiter_if.sv
// Bundle of N parallel decoupled channels of width W.
// A transfer on lane i happens on a clk edge where valid[i] && ready[i]; the
// producer holds data[i] stable while valid[i] is high, ready may depend on valid.
interface mem_rr_arbiter_if #(
    parameter int N = 1,
    parameter int W = 32
) ();
    logic [N-1:0]        valid;
    logic [N-1:0]        ready;
    logic [N-1:0][W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one memory slave among CNT masters, with per-master
// credit limits and an in-order route FIFO steering responses back to the issuer.
module mem_rr_arbiter #(
    parameter int CNT             = 2,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int QUEUE_DEPTH     = 4,
    parameter int MAX_OUTSTANDING = 2,
    localparam int IDXW           = (CNT > 1) ? $clog2(CNT) : 1
) (
    input  logic              clk,
    input  logic              rst,
    mem_rr_arbiter_if.slave   master_req,
    mem_rr_arbiter_if.master  master_resp,
    mem_rr_arbiter_if.master  slave_req,
    mem_rr_arbiter_if.slave   slave_resp,
    output logic [IDXW-1:0]   grant_idx,
    output logic              busy
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int QW = $clog2(QUEUE_DEPTH + 1);

    logic [IDXW-1:0]       last;
    logic [IDXW-1:0]       sel;
    logic [IDXW-1:0]       head;
    logic [CW-1:0]         outstanding [CNT];
    logic [IDXW-1:0]       route_q [QUEUE_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [QW-1:0]         count;
    logic [CNT-1:0]        elig;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  issue;
    logic                  retire;
    logic [ADDR_WIDTH-1:0] req_data;
    logic [DATA_WIDTH-1:0] resp_data;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(QUEUE_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        for (int i = 0; i < CNT; i++) begin
            elig[i] = master_req.valid[i] && (outstanding[i] < CW'(MAX_OUTSTANDING));
        end
    end

    // Scan starts just after the last winner, so the previous winner is checked last.
    always_comb begin
        logic            found;
        logic [IDXW-1:0] idx;
        sel   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= CNT; k++) begin
            idx = IDXW'((int'(last) + k) % CNT);
            if (!found && elig[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        fifo_empty          = (count == '0);
        fifo_full           = (count == QW'(QUEUE_DEPTH));
        head                = route_q[rd_ptr];
        req_data            = master_req.data[sel];
        resp_data           = slave_resp.data[0];
        slave_req.valid[0]  = (|elig) && !fifo_full && !rst;
        slave_req.data[0]   = req_data;
        issue               = slave_req.valid[0] && slave_req.ready[0];
        slave_resp.ready[0] = master_resp.ready[head] && !fifo_empty && !rst;
        retire              = slave_resp.valid[0] && slave_resp.ready[0];
        for (int i = 0; i < CNT; i++) begin
            master_req.ready[i]  = issue && (sel == IDXW'(i));
            master_resp.valid[i] = slave_resp.valid[0] && !fifo_empty && !rst && (head == IDXW'(i));
            master_resp.data[i]  = resp_data;
        end
        grant_idx = sel;
        busy      = !fifo_empty;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last   <= IDXW'(CNT - 1);
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < CNT; i++) begin
                outstanding[i] <= '0;
            end
        end else begin
            if (issue) begin
                last   <= sel;
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (retire) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (issue && !retire) begin
                count <= count + QW'(1);
            end else if (!issue && retire) begin
                count <= count - QW'(1);
            end
            // Issue and retire on the same master in one cycle cancel out.
            for (int i = 0; i < CNT; i++) begin
                if ((issue && sel == IDXW'(i)) && !(retire && head == IDXW'(i))) begin
                    outstanding[i] <= outstanding[i] + CW'(1);
                end else if (!(issue && sel == IDXW'(i)) && (retire && head == IDXW'(i))) begin
                    outstanding[i] <= outstanding[i] - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (issue) begin
            route_q[wr_ptr] <= sel;
        end
    end
endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Bench for mem_rr_arbiter: two instances (credit limit 2 and 4) share one stimulus
// stream; a list-based model predicts every output on each falling edge.
module tb_mem_rr_arbiter;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int QD   = 4;
    localparam int IDXW = 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [1:0]     m_valid = '0;
    logic [AW-1:0]  m_data [2];
    logic [1:0]     m_resp_ready = '0;
    logic           s_req_ready = 1'b0;
    logic           s_resp_valid = 1'b0;
    logic [DW-1:0]  s_resp_data = '0;

    logic [1:0]      obs_sreq_valid;
    logic [AW-1:0]   obs_sreq_data [2];
    logic [IDXW-1:0] obs_grant [2];
    logic [1:0]      obs_mreq_ready [2];
    logic [1:0]      obs_mresp_valid [2];
    logic [DW-1:0]   obs_mresp_data [2][2];
    logic [1:0]      obs_sresp_ready;
    logic [1:0]      obs_busy;

    int checks = 0;
    int errors = 0;
    int resp_seq = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_rr_arbiter_if #(.N(2), .W(AW)) mreq ();
        mem_rr_arbiter_if #(.N(2), .W(DW)) mresp ();
        mem_rr_arbiter_if #(.N(1), .W(AW)) sreq ();
        mem_rr_arbiter_if #(.N(1), .W(DW)) sresp ();
        logic [IDXW-1:0] grant;
        logic            busy;

        assign mreq.valid     = m_valid;
        assign mreq.data[0]   = m_data[0];
        assign mreq.data[1]   = m_data[1];
        assign mresp.ready    = m_resp_ready;
        assign sreq.ready[0]  = s_req_ready;
        assign sresp.valid[0] = s_resp_valid;
        assign sresp.data[0]  = s_resp_data;

        mem_rr_arbiter #(
            .CNT(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
            .QUEUE_DEPTH(QD), .MAX_OUTSTANDING(g == 0 ? 2 : 4)
        ) dut (
            .clk(clk), .rst(rst),
            .master_req(mreq), .master_resp(mresp),
            .slave_req(sreq), .slave_resp(sresp),
            .grant_idx(grant), .busy(busy)
        );

        assign obs_sreq_valid[g]    = sreq.valid[0];
        assign obs_sreq_data[g]     = sreq.data[0];
        assign obs_grant[g]         = grant;
        assign obs_mreq_ready[g]    = mreq.ready;
        assign obs_mresp_valid[g]   = mresp.valid;
        assign obs_mresp_data[g][0] = mresp.data[0];
        assign obs_mresp_data[g][1] = mresp.data[1];
        assign obs_sresp_ready[g]   = sresp.ready[0];
        assign obs_busy[g]          = busy;
    end

    task automatic check(input string name, input int g, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d at %0t: got %0h expected %0h", name, g, $time, act, exp);
        end
    endtask

    // Model: route list in issue order, credit count per master, last winner.
    int rq [2][QD];
    int rq_cnt [2] = '{0, 0};
    int last_m [2] = '{1, 1};
    int outst [2][2];
    int mx, sel, h, cand;
    bit found, full, empty, e_sreq_valid, issue, e_sresp_ready, retire;
    bit [1:0] elig, e_mreq_ready, e_mresp_valid;

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            mx = (g == 0) ? 2 : 4;
            for (int i = 0; i < 2; i++) elig[i] = m_valid[i] && (outst[g][i] < mx);
            sel = 0;
            found = 0;
            for (int k = 1; k <= 2; k++) begin
                cand = (last_m[g] + k) % 2;
                if (!found && elig[cand]) begin
                    sel = cand;
                    found = 1;
                end
            end
            full          = (rq_cnt[g] == QD);
            empty         = (rq_cnt[g] == 0);
            e_sreq_valid  = (elig != 0) && !full && !rst;
            issue         = e_sreq_valid && s_req_ready;
            h             = empty ? 0 : rq[g][0];
            e_sresp_ready = !empty && m_resp_ready[h] && !rst;
            retire        = s_resp_valid && e_sresp_ready;
            for (int i = 0; i < 2; i++) begin
                e_mreq_ready[i]  = issue && (sel == i);
                e_mresp_valid[i] = s_resp_valid && !empty && !rst && (h == i);
            end

            check("sreq_valid", g, obs_sreq_valid[g], e_sreq_valid);
            if (e_sreq_valid) begin
                check("grant_idx", g, obs_grant[g], sel);
                check("sreq_data", g, obs_sreq_data[g], m_data[sel]);
            end
            check("mreq_ready", g, obs_mreq_ready[g], e_mreq_ready);
            check("mresp_valid", g, obs_mresp_valid[g], e_mresp_valid);
            check("sresp_ready", g, obs_sresp_ready[g], e_sresp_ready);
            for (int i = 0; i < 2; i++) begin
                if (e_mresp_valid[i]) check("mresp_data", g, obs_mresp_data[g][i], s_resp_data);
            end
            if (!rst) check("busy", g, obs_busy[g], !empty);

            if (rst) begin
                last_m[g] = 1;
                rq_cnt[g] = 0;
                outst[g][0] = 0;
                outst[g][1] = 0;
            end else begin
                if (retire) begin
                    outst[g][h]--;
                    for (int k = 0; k < QD - 1; k++) rq[g][k] = rq[g][k + 1];
                    rq_cnt[g]--;
                end
                if (issue) begin
                    outst[g][sel]++;
                    rq[g][rq_cnt[g]] = sel;
                    rq_cnt[g]++;
                    last_m[g] = sel;
                end
            end
        end
    end

    // One bus cycle: drive just after the rising edge, return at the falling edge.
    task automatic cyc(input bit [1:0] mv, input bit sqr, input bit srv, input bit [1:0] mrr);
        @(posedge clk);
        #1;
        m_valid      = mv;
        s_req_ready  = sqr;
        s_resp_valid = srv;
        m_resp_ready = mrr;
        m_data[0]    = $urandom;
        m_data[1]    = $urandom;
        resp_seq++;
        s_resp_data  = 32'hD000_0000 + resp_seq;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        m_valid = '0;
        s_req_ready = 1'b0;
        s_resp_valid = 1'b0;
        m_resp_ready = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        m_data[0] = '0;
        m_data[1] = '0;
        repeat (2) @(posedge clk);

        // Reset held three cycles with both masters requesting.
        #1;
        rst = 1'b1;
        m_valid = 2'b11;
        s_req_ready = 1'b1;
        m_resp_ready = 2'b11;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                check("rst_sreq_valid", g, obs_sreq_valid[g], 1'b0);
                check("rst_mreq_ready", g, obs_mreq_ready[g], 2'b00);
                check("rst_sresp_ready", g, obs_sresp_ready[g], 1'b0);
            end
            @(posedge clk);
        end
        #1;
        rst = 1'b0;
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check("first_grant", g, obs_grant[g], 0);
            check("first_mreq_ready", g, obs_mreq_ready[g], 2'b01);
            check("busy_after_rst", g, obs_busy[g], 1'b0);
        end

        // Both masters always valid, response one cycle after each request.
        do_reset();
        for (int c = 0; c < 8; c++) begin
            cyc(2'b11, 1'b1, c >= 1, 2'b11);
            check("alt_grant", 0, obs_grant[0], c % 2);
            check("alt_route", 0, obs_mresp_valid[0], (c >= 1) ? (2'b01 << ((c - 1) % 2)) : 2'b00);
        end

        // Credit limit of two on master 0.
        do_reset();
        cyc(2'b01, 1'b1, 1'b0, 2'b11);
        check("credit_acc1", 0, obs_mreq_ready[0], 2'b01);
        cyc(2'b01, 1'b1, 1'b0, 2'b11);
        check("credit_acc2", 0, obs_mreq_ready[0], 2'b01);
        cyc(2'b01, 1'b1, 1'b0, 2'b11);
        check("credit_block", 0, obs_mreq_ready[0], 2'b00);
        check("credit_block_valid", 0, obs_sreq_valid[0], 1'b0);
        check("credit4_still_acc", 1, obs_mreq_ready[1], 2'b01);
        cyc(2'b11, 1'b1, 1'b0, 2'b11);
        check("credit_other_grant", 0, obs_grant[0], 1);
        check("credit_other_ready", 0, obs_mreq_ready[0], 2'b10);
        cyc(2'b01, 1'b1, 1'b1, 2'b11);
        check("credit_ret_ready", 0, obs_mreq_ready[0], 2'b00);
        check("credit_ret_route", 0, obs_mresp_valid[0], 2'b01);
        cyc(2'b01, 1'b1, 1'b0, 2'b11);
        check("credit_regrant", 0, obs_grant[0], 0);
        check("credit_regrant_rdy", 0, obs_mreq_ready[0], 2'b01);

        // Route FIFO fills at four entries on the credit-4 instance.
        do_reset();
        for (int c = 0; c < 4; c++) begin
            cyc(2'b11, 1'b1, 1'b0, 2'b11);
            check("fill_valid", 1, obs_sreq_valid[1], 1'b1);
            check("fill_grant", 1, obs_grant[1], c % 2);
        end
        cyc(2'b11, 1'b1, 1'b0, 2'b11);
        check("full_valid", 1, obs_sreq_valid[1], 1'b0);
        check("full_busy", 1, obs_busy[1], 1'b1);
        cyc(2'b11, 1'b1, 1'b1, 2'b11);
        check("full_pop_valid", 1, obs_sreq_valid[1], 1'b0);
        check("full_pop_route", 1, obs_mresp_valid[1], 2'b01);
        cyc(2'b11, 1'b1, 1'b0, 2'b11);
        check("after_pop_valid", 1, obs_sreq_valid[1], 1'b1);
        check("after_pop_grant", 1, obs_grant[1], 0);

        // Head-of-line stall: FIFO holds [1,0], master 1 not ready.
        do_reset();
        cyc(2'b10, 1'b1, 1'b0, 2'b11);
        check("hol_issue1", 0, obs_mreq_ready[0], 2'b10);
        cyc(2'b01, 1'b1, 1'b0, 2'b11);
        check("hol_issue0", 0, obs_mreq_ready[0], 2'b01);
        for (int c = 0; c < 3; c++) begin
            cyc(2'b00, 1'b1, 1'b1, 2'b01);
            check("hol_stall_ready", 0, obs_sresp_ready[0], 1'b0);
            check("hol_stall_route", 0, obs_mresp_valid[0], 2'b10);
        end
        cyc(2'b00, 1'b1, 1'b1, 2'b11);
        check("hol_rel_route1", 0, obs_mresp_valid[0], 2'b10);
        check("hol_rel_ready", 0, obs_sresp_ready[0], 1'b1);
        check("hol_rel_data", 0, obs_mresp_data[0][1], 32'hD000_0000 + resp_seq);
        cyc(2'b00, 1'b1, 1'b1, 2'b11);
        check("hol_rel_route0", 0, obs_mresp_valid[0], 2'b01);
        cyc(2'b00, 1'b1, 1'b0, 2'b11);
        check("hol_drained", 0, obs_busy[0], 1'b0);

        // Same-cycle issue and retire on master 0.
        do_reset();
        cyc(2'b01, 1'b1, 1'b0, 2'b11);
        check("same_first", 0, obs_mreq_ready[0], 2'b01);
        cyc(2'b01, 1'b1, 1'b1, 2'b11);
        check("same_issue", 0, obs_mreq_ready[0], 2'b01);
        check("same_retire", 0, obs_mresp_valid[0], 2'b01);
        check("same_sresp_ready", 0, obs_sresp_ready[0], 1'b1);
        cyc(2'b01, 1'b1, 1'b0, 2'b11);
        check("same_still_elig", 0, obs_mreq_ready[0], 2'b01);
        check("same_busy", 0, obs_busy[0], 1'b1);
        cyc(2'b01, 1'b1, 1'b0, 2'b11);
        check("same_now_limited", 0, obs_mreq_ready[0], 2'b00);

        // Random traffic, including a reset in the middle of in-flight work.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if (c == 200) do_reset();
            cyc(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
        end

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
